// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit owning the architectural HI/LO
// registers. MULT/MULTU use shift-add and DIV/DIVU use restoring division,
// one bit per cycle on operand magnitudes, with sign correction in FIX.
// MTHI/MTLO write HI/LO directly in one cycle.
// Optional macro MDU_FAST_MUL_EN: MULT/MULTU form the full product in a
// single cycle. Divide remains iterative.
module mdu_hilo #(
  parameter int XLEN  = 32,
  parameter int ITERS = XLEN
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] InputData1,
  input  logic [XLEN-1:0] InputData2,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic            DivByZero,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo
);

  localparam int CW = $clog2(ITERS + 1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] accHi_q, accHi_d;
  logic [XLEN-1:0] accLo_q, accLo_d;
  logic [XLEN-1:0] opB_q, opB_d;
  logic            negLo_q, negLo_d;
  logic            negHi_q, negHi_d;
  logic            isDiv_q, isDiv_d;
  logic            dbz_q, dbz_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic            signedOp;
  logic            signA;
  logic            signB;
  logic [XLEN-1:0] magA;
  logic [XLEN-1:0] magB;

  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     divShift;
  logic [XLEN:0]     divDiff;
  logic [2*XLEN-1:0] mulRes;
  logic [XLEN-1:0]   quotRes;
  logic [XLEN-1:0]   remRes;

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fastProd;

  // Whole unsigned magnitude product in one cycle; sign fixed up in FIX.
  always_comb begin
    fastProd = {{XLEN{1'b0}}, magA} * {{XLEN{1'b0}}, magB};
  end
`endif

  // Operand magnitudes and signs; only MULT and DIV treat operands as signed.
  always_comb begin
    signedOp = (Op == OpMult) || (Op == OpDiv);
    signA    = signedOp & InputData1[XLEN-1];
    signB    = signedOp & InputData2[XLEN-1];
    magA     = signA ? (-InputData1) : InputData1;
    magB     = signB ? (-InputData2) : InputData2;
  end

  // One iteration step of each algorithm plus the final sign correction.
  always_comb begin
    mulSum   = {1'b0, accHi_q} + {1'b0, (accLo_q[0] ? opB_q : {XLEN{1'b0}})};
    divShift = {accHi_q, accLo_q[XLEN-1]};
    divDiff  = divShift - {1'b0, opB_q};
    mulRes   = negLo_q ? (-{accHi_q, accLo_q}) : {accHi_q, accLo_q};
    quotRes  = negLo_q ? (-accLo_q) : accLo_q;
    remRes   = negHi_q ? (-accHi_q) : accHi_q;
  end

  // Next-state logic: issue from IDLE/DONE, iterate, then correct and commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accHi_d = accHi_q;
    accLo_d = accLo_q;
    opB_d   = opB_q;
    negLo_d = negLo_q;
    negHi_d = negHi_q;
    isDiv_d = isDiv_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (Start) begin
          case (Op)
            OpMthi: hi_d = InputData1;
            OpMtlo: lo_d = InputData1;
            OpMult, OpMultu: begin
              opB_d   = magA;
              accHi_d = '0;
              accLo_d = magB;
              negLo_d = signA ^ signB;
              negHi_d = 1'b0;
              isDiv_d = 1'b0;
              dbz_d   = 1'b0;
              cnt_d   = '0;
`ifdef MDU_FAST_MUL_EN
              {accHi_d, accLo_d} = fastProd;
              state_d = FIX;
`else
              state_d = MUL;
`endif
            end
            OpDiv, OpDivu: begin
              opB_d   = magB;
              accHi_d = '0;
              accLo_d = magA;
              negLo_d = signA ^ signB;
              negHi_d = signA;
              isDiv_d = 1'b1;
              dbz_d   = (InputData2 == '0);
              cnt_d   = '0;
              state_d = (InputData2 == '0) ? FIX : DIV;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        accHi_d = mulSum[XLEN:1];
        accLo_d = {mulSum[0], accLo_q[XLEN-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) begin
          state_d = FIX;
        end
      end
      DIV: begin
        if (!divDiff[XLEN]) begin
          accHi_d = divDiff[XLEN-1:0];
          accLo_d = {accLo_q[XLEN-2:0], 1'b1};
        end else begin
          accHi_d = divShift[XLEN-1:0];
          accLo_d = {accLo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
        if (!dbz_q) begin
          if (isDiv_q) begin
            hi_d = remRes;
            lo_d = quotRes;
          end else begin
            hi_d = mulRes[2*XLEN-1:XLEN];
            lo_d = mulRes[XLEN-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush kills whatever is in flight or being issued, including MTHI/MTLO.
    if (Flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      accHi_q <= '0;
      accLo_q <= '0;
      opB_q   <= '0;
      negLo_q <= 1'b0;
      negHi_q <= 1'b0;
      isDiv_q <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      accHi_q <= accHi_d;
      accLo_q <= accLo_d;
      opB_q   <= opB_d;
      negLo_q <= negLo_d;
      negHi_q <= negHi_d;
      isDiv_q <= isDiv_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Status decode: busy while iterating or fixing up, Done is the DONE state.
  always_comb begin
    Busy      = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
    Done      = (state_q == DONE);
    DivByZero = (state_q == DONE) && dbz_q;
    Hi        = hi_q;
    Lo        = lo_q;
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard bench for mdu_hilo. Expected Hi/Lo/DivByZero and
// latency are computed from plain 64-bit arithmetic when an operation is
// issued and compared when Done is seen. Honours MDU_FAST_MUL_EN.
module tb_mdu_hilo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] InputData1;
  logic [31:0] InputData2;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  mdu_hilo dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .Op(Op),
    .InputData1(InputData1),
    .InputData2(InputData2),
    .Flush(Flush),
    .Busy(Busy),
    .Done(Done),
    .DivByZero(DivByZero),
    .Hi(Hi),
    .Lo(Lo)
  );

  always #5 Clock = ~Clock;

  function automatic exp_t modelMul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sbv;
    logic [63:0] p;
    sa  = (op == 3'd0) ? longint'(signed'(a)) : longint'({32'b0, a});
    sbv = (op == 3'd0) ? longint'(signed'(b)) : longint'({32'b0, b});
    p     = 64'(sa * sbv);
    e.hi  = p[63:32];
    e.lo  = p[31:0];
    e.dbz = 1'b0;
    e.lat = MulLat;
    return e;
  endfunction

  function automatic exp_t modelDiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] curHi, input logic [31:0] curLo);
    exp_t        e;
    longint      sa;
    longint      sbv;
    logic [63:0] q;
    logic [63:0] r;
    if (b == 32'd0) begin
      e.hi  = curHi;
      e.lo  = curLo;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      sa  = (op == 3'd2) ? longint'(signed'(a)) : longint'({32'b0, a});
      sbv = (op == 3'd2) ? longint'(signed'(b)) : longint'({32'b0, b});
      q     = 64'(sa / sbv);
      r     = 64'(sa % sbv);
      e.hi  = r[31:0];
      e.lo  = q[31:0];
      e.dbz = 1'b0;
      e.lat = DivLat;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clock);
    Start      = 1'b1;
    Op         = op;
    InputData1 = a;
    InputData2 = b;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic waitDone(input int lat0, output int lat);
    lat = lat0;
    while (Done !== 1'b1 && lat < 200) begin
      @(negedge Clock);
      lat++;
    end
  endtask

  task automatic test_reset;
    logic sawDone;
    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; Op = 3'd0; InputData1 = '0; InputData2 = '0;
    repeat (2) @(negedge Clock);
    tests++; if (Hi !== 32'h0) begin fails++; $display("[TB] FAIL reset_hi: got %h expected %h", Hi, 32'h0); end
    tests++; if (Lo !== 32'h0) begin fails++; $display("[TB] FAIL reset_lo: got %h expected %h", Lo, 32'h0); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", Busy); end
    tests++; if (Done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", Done); end
    tests++; if (DivByZero !== 1'b0) begin fails++; $display("[TB] FAIL reset_dbz: got %b expected 0", DivByZero); end
    Reset = 1'b0;
    applyStimulus(3'd4, 32'h1234, 32'h0);
    tests++; if (Busy !== 1'b0 || Done !== 1'b0) begin fails++; $display("[TB] FAIL mthi_status: got busy=%b done=%b expected 0 0", Busy, Done); end
    applyStimulus(3'd5, 32'h5678, 32'h0);
    tests++; if (Hi !== 32'h1234) begin fails++; $display("[TB] FAIL mthi_hi: got %h expected %h", Hi, 32'h1234); end
    tests++; if (Lo !== 32'h5678) begin fails++; $display("[TB] FAIL mtlo_lo: got %h expected %h", Lo, 32'h5678); end
    applyStimulus(3'd0, 32'd7, 32'd9);
    repeat (9) @(negedge Clock);
    #1 Reset = 1'b1;
    #1;
    tests++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL midreset_busy: got %b expected 0", Busy); end
    tests++; if (Hi !== 32'h0 || Lo !== 32'h0) begin fails++; $display("[TB] FAIL midreset_hilo: got %h_%h expected 0_0", Hi, Lo); end
    @(negedge Clock);
    Reset = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (Done === 1'b1) sawDone = 1'b1;
    end
    tests++; if (sawDone !== 1'b0) begin fails++; $display("[TB] FAIL midreset_nodone: got %b expected 0", sawDone); end
  endtask

  task automatic test_mul;
    logic [2:0]  ops[5];
    logic [31:0] as[5];
    logic [31:0] bs[5];
    exp_t        e;
    int          lat;
    ops = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd1};
    as  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00010000, $urandom, $urandom};
    bs  = '{32'h00000003, 32'h00000003, 32'h00010000, $urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(modelMul(ops[i], as[i], bs[i]));
      applyStimulus(ops[i], as[i], bs[i]);
      tests++; if (Busy !== 1'b1) begin fails++; $display("[TB] FAIL mul_busy[%0d]: got %b expected 1", i, Busy); end
      waitDone(0, lat);
      e = sb.pop_front();
      tests++; if (lat !== e.lat) begin fails++; $display("[TB] FAIL mul_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
      tests++; if (Hi !== e.hi) begin fails++; $display("[TB] FAIL mul_hi[%0d]: got %h expected %h", i, Hi, e.hi); end
      tests++; if (Lo !== e.lo) begin fails++; $display("[TB] FAIL mul_lo[%0d]: got %h expected %h", i, Lo, e.lo); end
      tests++; if (DivByZero !== 1'b0) begin fails++; $display("[TB] FAIL mul_dbz[%0d]: got %b expected 0", i, DivByZero); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops[5];
    logic [31:0] as[5];
    logic [31:0] bs[5];
    exp_t        e;
    int          lat;
    ops = '{3'd2, 3'd3, 3'd2, 3'd3, 3'd2};
    as  = '{32'hFFFFFFF9, 32'd100, $urandom, $urandom, 32'h80000000};
    bs  = '{32'd2, 32'd7, $urandom | 32'h1, $urandom_range(1, 1000), 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(modelDiv(ops[i], as[i], bs[i], Hi, Lo));
      applyStimulus(ops[i], as[i], bs[i]);
      // A Start during Busy must be ignored, operands included.
      Start = 1'b1; Op = 3'd4; InputData1 = 32'hDEAD0000; InputData2 = 32'd1;
      @(negedge Clock);
      Start = 1'b0;
      waitDone(1, lat);
      e = sb.pop_front();
      tests++; if (lat !== e.lat) begin fails++; $display("[TB] FAIL div_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
      tests++; if (Hi !== e.hi) begin fails++; $display("[TB] FAIL div_hi[%0d]: got %h expected %h", i, Hi, e.hi); end
      tests++; if (Lo !== e.lo) begin fails++; $display("[TB] FAIL div_lo[%0d]: got %h expected %h", i, Lo, e.lo); end
      tests++; if (DivByZero !== 1'b0) begin fails++; $display("[TB] FAIL div_dbz[%0d]: got %b expected 0", i, DivByZero); end
    end
  endtask

  task automatic test_div_zero;
    exp_t e;
    int   lat;
    applyStimulus(3'd4, 32'h11, 32'h0);
    applyStimulus(3'd5, 32'h22, 32'h0);
    sb.push_back(modelDiv(3'd2, 32'd5, 32'd0, 32'h11, 32'h22));
    applyStimulus(3'd2, 32'd5, 32'd0);
    waitDone(0, lat);
    e = sb.pop_front();
    tests++; if (lat !== e.lat) begin fails++; $display("[TB] FAIL dbz_latency: got %0d expected %0d", lat, e.lat); end
    tests++; if (DivByZero !== e.dbz) begin fails++; $display("[TB] FAIL dbz_flag: got %b expected %b", DivByZero, e.dbz); end
    tests++; if (Hi !== e.hi) begin fails++; $display("[TB] FAIL dbz_hi: got %h expected %h", Hi, e.hi); end
    tests++; if (Lo !== e.lo) begin fails++; $display("[TB] FAIL dbz_lo: got %h expected %h", Lo, e.lo); end
    @(negedge Clock);
    tests++; if (DivByZero !== 1'b0 || Done !== 1'b0) begin fails++; $display("[TB] FAIL dbz_clear: got dbz=%b done=%b expected 0 0", DivByZero, Done); end
  endtask

  task automatic test_flush;
    logic sawDone;
    applyStimulus(3'd4, 32'hAA, 32'h0);
    applyStimulus(3'd5, 32'hBB, 32'h0);
    applyStimulus(3'd3, 32'd1000, 32'd3);
    repeat (3) @(negedge Clock);
    Flush = 1'b1;
    @(negedge Clock);
    Flush = 1'b0;
    tests++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_busy: got %b expected 0", Busy); end
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (Done === 1'b1) sawDone = 1'b1;
    end
    tests++; if (sawDone !== 1'b0) begin fails++; $display("[TB] FAIL flush_nodone: got %b expected 0", sawDone); end
    tests++; if (Hi !== 32'hAA || Lo !== 32'hBB) begin fails++; $display("[TB] FAIL flush_hilo: got %h_%h expected %h_%h", Hi, Lo, 32'hAA, 32'hBB); end
    @(negedge Clock);
    Start = 1'b1; Op = 3'd5; InputData1 = 32'h55; Flush = 1'b1;
    @(negedge Clock);
    Start = 1'b0; Flush = 1'b0;
    tests++; if (Lo !== 32'hBB) begin fails++; $display("[TB] FAIL flush_mtlo: got %h expected %h", Lo, 32'hBB); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_mtlo_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   lat;
    sb.push_back(modelDiv(3'd3, 32'd100, 32'd7, Hi, Lo));
    applyStimulus(3'd3, 32'd100, 32'd7);
    waitDone(0, lat);
    e = sb.pop_front();
    tests++; if (lat !== e.lat || Hi !== e.hi || Lo !== e.lo) begin fails++; $display("[TB] FAIL b2b_first: got lat=%0d %h_%h expected lat=%0d %h_%h", lat, Hi, Lo, e.lat, e.hi, e.lo); end
    // Issue again in the Done cycle, where Busy is already low.
    sb.push_back(modelMul(3'd1, 32'hFFFFFFFE, 32'h3));
    Start = 1'b1; Op = 3'd1; InputData1 = 32'hFFFFFFFE; InputData2 = 32'h3;
    @(negedge Clock);
    Start = 1'b0;
    waitDone(0, lat);
    e = sb.pop_front();
    tests++; if (lat !== e.lat) begin fails++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, e.lat); end
    tests++; if (Hi !== e.hi || Lo !== e.lo) begin fails++; $display("[TB] FAIL b2b_hilo: got %h_%h expected %h_%h", Hi, Lo, e.hi, e.lo); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
